// File: rtl/ram_dma_stride_ci_if.sv
// Shared-bus master/slave signal bundle used by the stride DMA engine.
interface ram_dma_stride_ci_if;
  logic        requestTransaction;
  logic        transactionGranted;
  logic [31:0] addressDataIn;
  logic        dataValidIn;
  logic        endTransactionIn;
  logic        busErrorIn;
  logic        busyIn;
  logic [31:0] addressDataOut;
  logic [3:0]  byteEnablesOut;
  logic [7:0]  burstSizeOut;
  logic        readNotWriteOut;
  logic        beginTransactionOut;
  logic        endTransactionOut;
  logic        dataValidOut;

  modport master (
    output requestTransaction, addressDataOut, byteEnablesOut, burstSizeOut,
           readNotWriteOut, beginTransactionOut, endTransactionOut, dataValidOut,
    input  transactionGranted, addressDataIn, dataValidIn, endTransactionIn,
           busErrorIn, busyIn
  );

  modport slave (
    input  requestTransaction, addressDataOut, byteEnablesOut, burstSizeOut,
           readNotWriteOut, beginTransactionOut, endTransactionOut, dataValidOut,
    output transactionGranted, addressDataIn, dataValidIn, endTransactionIn,
           busErrorIn, busyIn
  );
endinterface

// File: rtl/ram_dma_stride_ci.sv
// Custom-instruction DMA: CPU-visible dual-port SRAM plus a strided burst bus master
// with sticky bus-error abort and a status register.
module ram_dma_stride_ci #(
  parameter logic [7:0] customId       = 8'd14,
  parameter int         MEM_ADDR_WIDTH = 9,
  parameter int         BLOCK_WIDTH    = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result,
  ram_dma_stride_ci_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ, INIT, RDATA, WDATA, WEND, NEXT, ERR} state_t;

  state_t state_r, nextState_s;

  logic [31:0]               mem_r [0:(1<<MEM_ADDR_WIDTH)-1];
  logic [31:0]               busAddr_r, stride_r, curBus_r;
  logic [MEM_ADDR_WIDTH-1:0] memAddr_r, cur_r;
  logic [BLOCK_WIDTH-1:0]    blockSize_r, remaining_r;
  logic [7:0]                burst_r;
  logic [8:0]                burstWords_r, beatsLeft_r, burstLess_s;
  logic                      busy_r, errSticky_r, dirRead_r;

  logic                      ciHit_s, ciWe_s, ciMemWe_s, dmaMemWe_s, startAccept_s, enterErr_s;
  logic [2:0]                ciSel_s;
  logic [MEM_ADDR_WIDTH-1:0] ciAddr_s;
  logic [31:0]               burstPlus_s, remainExt_s, burstWords_s, readMux_s;
  logic                      unusedBits_s;

  assign ciHit_s       = start && (ciN == customId);
  assign ciWe_s        = valueA[9];
  assign ciSel_s       = valueA[12:10];
  assign ciAddr_s      = valueA[MEM_ADDR_WIDTH-1:0];
  assign ciMemWe_s     = ciHit_s && ciWe_s && (ciSel_s == 3'd0);
  assign dmaMemWe_s    = (state_r == RDATA) && bus.dataValidIn && !bus.busErrorIn;
  assign startAccept_s = ciHit_s && ciWe_s && (ciSel_s == 3'd5) && !busy_r && (state_r == IDLE)
                         && ((valueB[1:0] == 2'd1) || (valueB[1:0] == 2'd2))
                         && (blockSize_r != BLOCK_WIDTH'(0));
  assign enterErr_s    = (nextState_s == ERR) && (state_r != ERR);
  assign burstPlus_s   = {24'd0, burst_r} + 32'd1;
  assign remainExt_s   = 32'(remaining_r);
  assign burstWords_s  = (burstPlus_s < remainExt_s) ? burstPlus_s : remainExt_s;
  assign burstLess_s   = burstWords_r - 9'd1;
  assign unusedBits_s  = ^{valueA[31:13], burstWords_s[31:9], burstLess_s[8]};

  // Dual-port SRAM write; the DMA port is written last so it wins on a collision.
  always_ff @(posedge clock) begin
    if (ciMemWe_s) mem_r[ciAddr_s] <= valueB;
    if (dmaMemWe_s) mem_r[cur_r] <= bus.addressDataIn;
  end

  // CI read-data selection.
  always_comb begin
    readMux_s = 32'd0;
    case (ciSel_s)
      3'd0:    readMux_s = mem_r[ciAddr_s];
      3'd1:    readMux_s = busAddr_r;
      3'd2:    readMux_s = {{(32-MEM_ADDR_WIDTH){1'b0}}, memAddr_r};
      3'd3:    readMux_s = {{(32-BLOCK_WIDTH){1'b0}}, blockSize_r};
      3'd4:    readMux_s = {24'd0, burst_r};
      3'd5:    readMux_s = {29'd0, errSticky_r, errSticky_r, busy_r};
      3'd6:    readMux_s = stride_r;
      default: readMux_s = 32'd0;
    endcase
  end

  // Registered CI completion; result stays zero outside the done cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done   <= 1'b0;
      result <= 32'd0;
    end else begin
      done   <= ciHit_s;
      result <= (ciHit_s && !ciWe_s) ? readMux_s : 32'd0;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= nextState_s;
  end

  // FSM next-state; a bus error in any active bus phase aborts the block.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE:    if (startAccept_s) nextState_s = REQ; else nextState_s = IDLE;
      REQ:     if (bus.transactionGranted) nextState_s = INIT; else nextState_s = REQ;
      INIT:    if (bus.busErrorIn) nextState_s = ERR;
               else if (dirRead_r) nextState_s = RDATA;
               else nextState_s = WDATA;
      RDATA:   if (bus.busErrorIn) nextState_s = ERR;
               else if (bus.endTransactionIn) nextState_s = NEXT;
               else nextState_s = RDATA;
      WDATA:   if (bus.busErrorIn) nextState_s = ERR;
               else if (!bus.busyIn && (beatsLeft_r == 9'd1)) nextState_s = WEND;
               else nextState_s = WDATA;
      WEND:    if (bus.busErrorIn) nextState_s = ERR; else nextState_s = NEXT;
      NEXT:    if (remaining_r == BLOCK_WIDTH'(0)) nextState_s = IDLE; else nextState_s = REQ;
      ERR:     nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // Configuration, status and transfer bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busAddr_r    <= 32'd0;
      stride_r     <= 32'd0;
      curBus_r     <= 32'd0;
      memAddr_r    <= MEM_ADDR_WIDTH'(0);
      cur_r        <= MEM_ADDR_WIDTH'(0);
      blockSize_r  <= BLOCK_WIDTH'(0);
      remaining_r  <= BLOCK_WIDTH'(0);
      burst_r      <= 8'd0;
      burstWords_r <= 9'd0;
      beatsLeft_r  <= 9'd0;
      busy_r       <= 1'b0;
      errSticky_r  <= 1'b0;
      dirRead_r    <= 1'b0;
    end else begin
      if (ciHit_s && ciWe_s && !busy_r) begin
        case (ciSel_s)
          3'd1:    busAddr_r   <= {valueB[31:2], 2'b00};
          3'd2:    memAddr_r   <= valueB[MEM_ADDR_WIDTH-1:0];
          3'd3:    blockSize_r <= valueB[BLOCK_WIDTH-1:0];
          3'd4:    burst_r     <= valueB[7:0];
          3'd6:    stride_r    <= {valueB[31:2], 2'b00};
          default: ;
        endcase
      end
      if (startAccept_s) begin
        busy_r      <= 1'b1;
        errSticky_r <= 1'b0;
        dirRead_r   <= (valueB[1:0] == 2'd1);
        cur_r       <= memAddr_r;
        remaining_r <= blockSize_r;
        curBus_r    <= busAddr_r;
      end
      case (state_r)
        REQ: if (bus.transactionGranted) begin
          burstWords_r <= burstWords_s[8:0];
          beatsLeft_r  <= burstWords_s[8:0];
        end
        RDATA: if (dmaMemWe_s) begin
          cur_r       <= cur_r + MEM_ADDR_WIDTH'(1);
          remaining_r <= remaining_r - BLOCK_WIDTH'(1);
        end
        WDATA: if (!bus.busErrorIn && !bus.busyIn) begin
          cur_r       <= cur_r + MEM_ADDR_WIDTH'(1);
          remaining_r <= remaining_r - BLOCK_WIDTH'(1);
          beatsLeft_r <= beatsLeft_r - 9'd1;
        end
        NEXT: begin
          curBus_r <= curBus_r + {21'd0, burstWords_r, 2'b00} + stride_r;
          if (remaining_r == BLOCK_WIDTH'(0)) busy_r <= 1'b0;
        end
        default: ;
      endcase
      if (enterErr_s) begin
        errSticky_r <= 1'b1;
        busy_r      <= 1'b0;
      end
    end
  end

  // Bus outputs decoded from the state register; zero outside their phases.
  always_comb begin
    bus.requestTransaction  = 1'b0;
    bus.beginTransactionOut = 1'b0;
    bus.endTransactionOut   = 1'b0;
    bus.dataValidOut        = 1'b0;
    bus.readNotWriteOut     = 1'b0;
    bus.addressDataOut      = 32'd0;
    bus.byteEnablesOut      = 4'h0;
    bus.burstSizeOut        = 8'd0;
    case (state_r)
      REQ:  bus.requestTransaction = 1'b1;
      INIT: begin
        bus.beginTransactionOut = 1'b1;
        bus.addressDataOut      = curBus_r;
        bus.burstSizeOut        = burstLess_s[7:0];
        bus.readNotWriteOut     = dirRead_r;
      end
      WDATA: begin
        bus.addressDataOut = mem_r[cur_r];
        bus.dataValidOut   = 1'b1;
        bus.byteEnablesOut = 4'hF;
      end
      WEND:    bus.endTransactionOut = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_dma_stride_ci.sv
// Directed bench for ram_dma_stride_ci: the bench plays CPU and bus slave/arbiter.
module tb_ram_dma_stride_ci;
  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA, valueB;
  logic        done;
  logic [31:0] result;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] rd;
  logic        sawReq;

  ram_dma_stride_ci_if busIf();

  ram_dma_stride_ci dut (
    .clock(clock), .reset(reset), .start(start), .ciN(ciN),
    .valueA(valueA), .valueB(valueB), .done(done), .result(result),
    .bus(busIf)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ciOp(input logic [2:0] sel, input logic we, input logic [8:0] addr,
                      input logic [31:0] data, output logic [31:0] rdata);
    start  = 1'b1;
    ciN    = 8'd14;
    valueA = {19'd0, sel, we, addr};
    valueB = data;
    tick();
    start  = 1'b0;
    check("ci_done", 32'(done), 32'd1);
    rdata  = result;
  endtask

  task automatic ciWr(input logic [2:0] sel, input logic [8:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    ciOp(sel, 1'b1, addr, data, dummy);
  endtask

  task automatic ciRd(input string tag, input logic [2:0] sel, input logic [8:0] addr,
                      input logic [31:0] exp);
    logic [31:0] r;
    ciOp(sel, 1'b0, addr, 32'd0, r);
    check(tag, r, exp);
  endtask

  task automatic grantBurst(input string tag, input logic [31:0] expAddr,
                            input logic [7:0] expSize, input logic expRnw);
    for (int i = 0; i < 30 && busIf.requestTransaction !== 1'b1; i++) tick();
    check({tag, "_req"}, 32'(busIf.requestTransaction), 32'd1);
    busIf.transactionGranted = 1'b1;
    tick();
    busIf.transactionGranted = 1'b0;
    check({tag, "_begin"}, 32'(busIf.beginTransactionOut), 32'd1);
    check({tag, "_addr"}, busIf.addressDataOut, expAddr);
    check({tag, "_size"}, 32'(busIf.burstSizeOut), 32'(expSize));
    check({tag, "_rnw"}, 32'(busIf.readNotWriteOut), 32'(expRnw));
    tick();
  endtask

  task automatic readBurst(input logic [31:0] base, input logic [31:0] step, input int n);
    for (int i = 0; i < n; i++) begin
      busIf.dataValidIn      = 1'b1;
      busIf.addressDataIn    = base + step * 32'(i);
      busIf.endTransactionIn = (i == n - 1);
      tick();
    end
    busIf.dataValidIn      = 1'b0;
    busIf.endTransactionIn = 1'b0;
    busIf.addressDataIn    = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; ciN = 8'd0; valueA = 32'd0; valueB = 32'd0;
    busIf.transactionGranted = 1'b0; busIf.addressDataIn = 32'd0; busIf.dataValidIn = 1'b0;
    busIf.endTransactionIn = 1'b0; busIf.busErrorIn = 1'b0; busIf.busyIn = 1'b0;
    #2;
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_req", 32'(busIf.requestTransaction), 32'd0);
    check("rst_addr", busIf.addressDataOut, 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Two-burst read with a short final burst; bus address bits [1:0] are forced low.
    ciWr(3'd1, 9'd0, 32'h103);
    ciRd("busaddr_align", 3'd1, 9'd0, 32'h100);
    tick();
    check("result_idle_zero", result, 32'd0);
    ciWr(3'd2, 9'd0, 32'd0);
    ciWr(3'd3, 9'd0, 32'd6);
    ciWr(3'd4, 9'd0, 32'd3);
    ciWr(3'd6, 9'd0, 32'd0);
    ciWr(3'd5, 9'd0, 32'd1);
    ciRd("status_busy", 3'd5, 9'd0, 32'h1);
    grantBurst("rd1", 32'h100, 8'd3, 1'b1);
    readBurst(32'd10, 32'd10, 4);
    grantBurst("rd2", 32'h110, 8'd1, 1'b1);
    readBurst(32'd50, 32'd10, 2);
    tick();
    ciRd("status_done", 3'd5, 9'd0, 32'h0);
    ciRd("sram0", 3'd0, 9'd0, 32'd10);
    ciRd("sram3", 3'd0, 9'd3, 32'd40);
    ciRd("sram5", 3'd0, 9'd5, 32'd60);

    // Inter-burst stride.
    ciWr(3'd2, 9'd0, 32'd16);
    ciWr(3'd6, 9'd0, 32'd8);
    ciWr(3'd3, 9'd0, 32'd4);
    ciWr(3'd4, 9'd0, 32'd1);
    ciWr(3'd5, 9'd0, 32'd1);
    grantBurst("st1", 32'h100, 8'd1, 1'b1);
    readBurst(32'h71, 32'd1, 2);
    grantBurst("st2", 32'h110, 8'd1, 1'b1);
    readBurst(32'h73, 32'd1, 2);
    tick();
    ciRd("st_status", 3'd5, 9'd0, 32'h0);
    ciRd("st_sram16", 3'd0, 9'd16, 32'h71);
    ciRd("st_sram19", 3'd0, 9'd19, 32'h74);

    // Write with a slave stall mid-burst.
    for (int i = 0; i < 5; i++) ciWr(3'd0, 9'(32 + i), 32'(i + 1));
    ciWr(3'd1, 9'd0, 32'h200);
    ciWr(3'd2, 9'd0, 32'd32);
    ciWr(3'd3, 9'd0, 32'd5);
    ciWr(3'd6, 9'd0, 32'd0);
    ciWr(3'd5, 9'd0, 32'd2);
    grantBurst("wr1", 32'h200, 8'd1, 1'b0);
    check("wr1_dv", 32'(busIf.dataValidOut), 32'd1);
    check("wr1_be", 32'(busIf.byteEnablesOut), 32'hF);
    check("wr1_d0", busIf.addressDataOut, 32'd1);
    tick();
    check("wr1_d1", busIf.addressDataOut, 32'd2);
    busIf.busyIn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("wr1_hold_data", busIf.addressDataOut, 32'd2);
      check("wr1_hold_dv", 32'(busIf.dataValidOut), 32'd1);
    end
    busIf.busyIn = 1'b0;
    tick();
    check("wr1_end", 32'(busIf.endTransactionOut), 32'd1);
    check("wr1_end_dv", 32'(busIf.dataValidOut), 32'd0);
    tick();
    grantBurst("wr2", 32'h208, 8'd1, 1'b0);
    check("wr2_d0", busIf.addressDataOut, 32'd3);
    tick();
    check("wr2_d1", busIf.addressDataOut, 32'd4);
    tick();
    check("wr2_end", 32'(busIf.endTransactionOut), 32'd1);
    tick();
    grantBurst("wr3", 32'h210, 8'd0, 1'b0);
    check("wr3_d0", busIf.addressDataOut, 32'd5);
    tick();
    check("wr3_end", 32'(busIf.endTransactionOut), 32'd1);
    tick(); tick();
    ciRd("wr_status", 3'd5, 9'd0, 32'h0);

    // Bus error during the second read burst, then recovery.
    ciWr(3'd1, 9'd0, 32'h100);
    ciWr(3'd2, 9'd0, 32'd0);
    ciWr(3'd3, 9'd0, 32'd6);
    ciWr(3'd4, 9'd0, 32'd3);
    ciWr(3'd5, 9'd0, 32'd1);
    grantBurst("er1", 32'h100, 8'd3, 1'b1);
    readBurst(32'd1, 32'd1, 4);
    grantBurst("er2", 32'h110, 8'd1, 1'b1);
    busIf.busErrorIn = 1'b1;
    tick();
    busIf.busErrorIn = 1'b0;
    check("err_req", 32'(busIf.requestTransaction), 32'd0);
    check("err_rnw", 32'(busIf.readNotWriteOut), 32'd0);
    check("err_addr", busIf.addressDataOut, 32'd0);
    check("err_begin", 32'(busIf.beginTransactionOut), 32'd0);
    ciRd("err_status", 3'd5, 9'd0, 32'h6);
    ciWr(3'd5, 9'd0, 32'd1);
    ciRd("err_cleared", 3'd5, 9'd0, 32'h1);

    // Control and config writes while busy are ignored.
    ciWr(3'd5, 9'd0, 32'd2);
    ciWr(3'd3, 9'd0, 32'd0);
    ciRd("busy_block_kept", 3'd3, 9'd0, 32'd6);
    ciRd("busy_status", 3'd5, 9'd0, 32'h1);
    grantBurst("bz1", 32'h100, 8'd3, 1'b1);
    readBurst(32'd1, 32'd1, 4);
    grantBurst("bz2", 32'h110, 8'd1, 1'b1);
    readBurst(32'd5, 32'd1, 2);
    tick();
    ciRd("bz_status", 3'd5, 9'd0, 32'h0);

    // Zero-length block never starts.
    ciWr(3'd3, 9'd0, 32'd0);
    ciWr(3'd5, 9'd0, 32'd1);
    sawReq = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sawReq = sawReq | busIf.requestTransaction;
      tick();
    end
    check("blk0_noreq", 32'(sawReq), 32'd0);
    ciRd("blk0_status", 3'd5, 9'd0, 32'h0);

    // Asynchronous reset in the middle of a write burst.
    ciWr(3'd1, 9'd0, 32'h300);
    ciWr(3'd2, 9'd0, 32'd32);
    ciWr(3'd3, 9'd0, 32'd4);
    ciWr(3'd4, 9'd0, 32'd3);
    ciWr(3'd5, 9'd0, 32'd2);
    grantBurst("rw1", 32'h300, 8'd3, 1'b0);
    check("rw_dv_before", 32'(busIf.dataValidOut), 32'd1);
    reset = 1'b1;
    #1;
    check("rw_dv_reset", 32'(busIf.dataValidOut), 32'd0);
    check("rw_addr_reset", busIf.addressDataOut, 32'd0);
    check("rw_be_reset", 32'(busIf.byteEnablesOut), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rw_req_after", 32'(busIf.requestTransaction), 32'd0);
    ciRd("rw_status", 3'd5, 9'd0, 32'h0);
    ciRd("rw_block", 3'd3, 9'd0, 32'd0);
    ciRd("rw_busaddr", 3'd1, 9'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
